uart_program_loader: RTL and testbench
======================================

// Module: uart_program_loader
// PURPOSE
//  Sits between uart_engine's RX outputs and instruction memory inside soc_wrapper_vivado.
//  While programmer_mode is high, it packs received UART bytes into little-endian 32-bit words.
//  Byte k of a word lands in wdata[k*8+:8].
//  Each word is written to instruction RAM at consecutive word addresses through a valid/ready write port.
//  The CPU core is held in reset until the load has finished.
// PARAMETERS
//  ADDR_W        12        word-address width of the instruction RAM port
//  MEM_DEPTH     4096      words accepted before overflow (<= 2**ADDR_W)
//  BASE_ADDR     0         word address of the first written word
// PORTS
//  clk              in   1       system clock
//  resetn           in   1       async active-low reset
//  programmer_mode  in   1       level; high = load session active
//  rx_valid_i       in   1       1-cycle pulse from uart_engine rx_received_o
//  rx_data_i        in   8       byte, valid with rx_valid_i
//  mem_valid_o      out  1       write request
//  mem_ready_i      in   1       RAM accepts the write when valid && ready
//  mem_addr_o       out  ADDR_W  word address
//  mem_wdata_o      out  32      write data
//  mem_wstrb_o      out  4       byte enables
//  cpu_resetn_o     out  1       low = hold CPU in reset
//  word_count_o     out  ADDR_W+1  words written this session
//  done_o           out  1       1-cycle pulse when the session completes
//  overflow_o       out  1       sticky: a byte was dropped (depth exceeded or overrun)
// BEHAVIOUR
//  Reset values:
//   - mem_valid_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, mem_wstrb_o=0.
//   - cpu_resetn_o=0, word_count_o=0, done_o=0, overflow_o=0.
//   - FSM state = IDLE.
//  FSM states: IDLE, COLLECT, WRITE, FLUSH, DONE.
//  IDLE:
//   - cpu_resetn_o=1.
//   - A rising edge of programmer_mode clears word_count, overflow, byte_idx and address, then -> COLLECT.
//   - rx_valid_i is ignored in IDLE.
//  COLLECT (cpu_resetn_o=0):
//   - On rx_valid_i, store the byte at lane byte_idx, set that strobe bit, byte_idx++.
//   - When byte_idx wraps 3->0 -> WRITE.
//   - When programmer_mode falls: if byte_idx!=0 -> FLUSH; else -> DONE.
//  WRITE:
//   - mem_valid_o=1. Addr, wdata and wstrb stay stable until the handshake.
//   - Handshake (valid && ready): address++, word_count++, clear the lanes, -> COLLECT.
//   - When ready is already high on entry, the handshake completes in the first WRITE cycle.
//   - Latency from the 4th byte pulse to the first mem_valid_o cycle is 1 clk.
//  One-byte skid register:
//   - An rx_valid_i arriving during WRITE is held and consumed as lane 0 on return to COLLECT.
//   - A second byte arriving while the skid is full is dropped and sets overflow_o.
//  FLUSH:
//   - Same as WRITE, using the partial word. Unfilled lanes are 0 with wstrb=0.
//   - After the handshake -> DONE.
//  Depth limit:
//   - When word_count == MEM_DEPTH, no further writes are issued.
//   - Further bytes are dropped and overflow_o is set.
//  DONE:
//   - done_o=1 for one cycle, then -> IDLE, which releases cpu_resetn_o.
//  programmer_mode falling during WRITE:
//   - The pending write completes first.
//   - Then -> FLUSH if a skid byte or partial lanes are present, else -> DONE.
//  programmer_mode rising again while in DONE/IDLE starts a new session from BASE_ADDR.
//  Async resetn low mid-session:
//   - Takes effect immediately.
//   - Any pending write is abandoned (mem_valid_o=0).
//   - After release the FSM is in IDLE; a new session needs a fresh programmer_mode rise.
//  Width rules:
//   - mem_addr_o wraps modulo 2**ADDR_W; the depth limit normally prevents reaching the wrap.
//   - word_count_o saturates at MEM_DEPTH.
// TESTING
//  1) Stream bytes 13,00,00,00,93,00,10,00, then drop mode.
//     -> writes 0x00000013@0 and 0x00100093@1, wstrb=F.
//     -> word_count=2, one done_o pulse, then cpu_resetn_o=1.
//  2) Stream 5 bytes AA,BB,CC,DD,EE, then drop mode.
//     -> 0xDDCCBBAA@0, then flush 0x000000EE@1 with wstrb=1, done_o.
//  3) Hold mem_ready_i=0 for 20 clk in WRITE while 1 byte arrives, then a second byte.
//     -> mem_valid_o/addr/data stable throughout.
//     -> first byte kept via skid, second dropped, overflow_o=1.
//  4) MEM_DEPTH=2, send 12 bytes.
//     -> exactly 2 writes, overflow_o=1, word_count_o=2.
//  5) Assert resetn=0 mid-word (after 2 bytes).
//     -> all outputs return to reset values and no write is issued.
//     -> a new session rewrites from address 0.
//  6) Drop mode during a stalled WRITE with 0 residual bytes.
//     -> write completes, done_o 1 cycle after the handshake, no FLUSH write.

Source files
------------

// File: rtl/uart_program_loader.sv
// Packs UART RX bytes into little-endian 32-bit words and writes them to instruction RAM
// through a valid/ready port while holding the CPU in reset for the duration of the load.
module uart_program_loader #(
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              programmer_mode,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    output logic              cpu_resetn_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              done_o,
    output logic              overflow_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_mode_d;
    logic                r_cpu_resetn;
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_data;
    logic [3:0]          r_strb;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_word_count;
    logic                r_overflow;
    logic                r_skid_valid;
    logic [7:0]          r_skid_data;

    logic                w_rise;
    logic                w_start;
    logic                w_full;
    logic                w_byte_avail;
    logic [7:0]          w_byte;
    logic                w_take;
    logic                w_word_done;
    logic                w_skid_hold;
    logic [1:0]          w_idx_after;
    logic                w_handshake;

    assign w_rise       = programmer_mode & ~r_mode_d;
    assign w_start      = w_rise & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_full       = (r_word_count == DEPTH);
    // The skid byte is older than any byte on the bus, so it always goes first.
    assign w_byte_avail = r_skid_valid | rx_valid_i;
    assign w_byte       = r_skid_valid ? r_skid_data : rx_data_i;
    assign w_take       = (r_state == ST_COLLECT) & w_byte_avail & ~w_full;
    assign w_word_done  = w_take & (r_byte_idx == 2'd3);
    assign w_skid_hold  = w_take & r_skid_valid & rx_valid_i;
    assign w_idx_after  = w_take ? r_byte_idx + 2'd1 : r_byte_idx;
    assign w_handshake  = mem_valid_o & mem_ready_i;

    assign mem_valid_o  = (r_state == ST_WRITE) | (r_state == ST_FLUSH);
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_data;
    assign mem_wstrb_o  = r_strb;
    assign cpu_resetn_o = r_cpu_resetn;
    assign word_count_o = r_word_count;
    assign done_o       = (r_state == ST_DONE);
    assign overflow_o   = r_overflow;

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_word_done) begin
                    w_state_next = ST_WRITE;
                end else if (!programmer_mode && !w_skid_hold) begin
                    w_state_next = (w_idx_after != 2'd0) ? ST_FLUSH : ST_DONE;
                end
            end
            ST_WRITE: begin
                // A held byte must pass through COLLECT so it lands in lane 0 before the flush.
                if (mem_ready_i) begin
                    w_state_next = (programmer_mode || r_skid_valid || rx_valid_i)
                                   ? ST_COLLECT : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (mem_ready_i) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = w_start ? ST_COLLECT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_mode_d resets high so a mode level held across reset is not mistaken for a new rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mode_d     <= 1'b1;
            r_cpu_resetn <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_data       <= 32'd0;
            r_strb       <= 4'd0;
            r_addr       <= BASE;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 8'd0;
        end else begin
            r_mode_d     <= programmer_mode;
            r_cpu_resetn <= (w_state_next == ST_IDLE);

            if (w_start) begin
                r_byte_idx   <= 2'd0;
                r_data       <= 32'd0;
                r_strb       <= 4'd0;
                r_addr       <= BASE;
                r_word_count <= '0;
                r_overflow   <= 1'b0;
                r_skid_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_COLLECT: begin
                        if (w_full) begin
                            if (w_byte_avail) r_overflow <= 1'b1;
                            r_skid_valid <= 1'b0;
                        end else if (w_take) begin
                            r_data[{r_byte_idx, 3'b000} +: 8] <= w_byte;
                            r_strb[r_byte_idx]                <= 1'b1;
                            r_byte_idx                        <= r_byte_idx + 2'd1;
                            if (r_skid_valid) begin
                                r_skid_valid <= rx_valid_i;
                                r_skid_data  <= rx_data_i;
                            end
                        end
                    end
                    ST_WRITE, ST_FLUSH: begin
                        if (r_state == ST_WRITE && rx_valid_i) begin
                            if (r_skid_valid) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_skid_valid <= 1'b1;
                                r_skid_data  <= rx_data_i;
                            end
                        end
                        if (w_handshake) begin
                            r_addr     <= r_addr + ADDR_ONE;
                            r_data     <= 32'd0;
                            r_strb     <= 4'd0;
                            r_byte_idx <= 2'd0;
                            if (!w_full) r_word_count <= r_word_count + CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: word packing, flush, skid/overrun, depth limit,
// async reset mid-word and a mode drop during a stalled write.
module tb_uart_program_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        programmer_mode;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_ready;

    logic        mem_valid;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        cpu_resetn;
    logic [12:0] word_count;
    logic        done;
    logic        overflow;

    logic        s_valid;
    logic [11:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_cpu_resetn;
    logic [12:0] s_word_count;
    logic        s_done;
    logic        s_overflow;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_done   = 0;
    int          n_small_wr = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q_strb[$];

    always #5 clk = ~clk;

    uart_program_loader dut (
        .clk(clk), .resetn(resetn), .programmer_mode(programmer_mode),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .cpu_resetn_o(cpu_resetn),
        .word_count_o(word_count), .done_o(done), .overflow_o(overflow)
    );

    uart_program_loader #(.ADDR_W(12), .MEM_DEPTH(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .resetn(resetn), .programmer_mode(programmer_mode),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .mem_valid_o(s_valid), .mem_ready_i(mem_ready), .mem_addr_o(s_addr),
        .mem_wdata_o(s_wdata), .mem_wstrb_o(s_wstrb), .cpu_resetn_o(s_cpu_resetn),
        .word_count_o(s_word_count), .done_o(s_done), .overflow_o(s_overflow)
    );

    // Handshakes are observed half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (mem_valid && mem_ready) begin
            q_addr.push_back({20'd0, mem_addr});
            q_data.push_back(mem_wdata);
            q_strb.push_back({28'd0, mem_wstrb});
        end
        if (s_valid && mem_ready) n_small_wr++;
        if (done) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        q_addr.delete();
        q_data.delete();
        q_strb.delete();
        n_done     = 0;
        n_small_wr = 0;
        programmer_mode = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic end_session(input string tag);
        programmer_mode = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (n_done > 0) break;
        end
        tick();
        tick();
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_cpu_release"}, cpu_resetn, 1'b1);
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] s);
        if (q_addr.size() > idx) begin
            check({tag, "_addr"}, q_addr[idx], a);
            check({tag, "_data"}, q_data[idx], d);
            check({tag, "_strb"}, q_strb[idx], s);
        end else begin
            check({tag, "_missing"}, q_addr.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stable;
        logic [11:0] cap_addr;
        logic [31:0] cap_data;
        logic [3:0]  cap_strb;

        resetn          = 1'b0;
        programmer_mode = 1'b0;
        rx_valid        = 1'b0;
        rx_data         = 8'd0;
        mem_ready       = 1'b1;
        tick();
        check("rst_valid",    mem_valid, 1'b0);
        check("rst_addr",     mem_addr, 12'd0);
        check("rst_wdata",    mem_wdata, 32'd0);
        check("rst_wstrb",    mem_wstrb, 4'd0);
        check("rst_cpu",      cpu_resetn, 1'b0);
        check("rst_count",    word_count, 13'd0);
        check("rst_done",     done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        resetn = 1'b1;
        tick();
        tick();
        check("idle_cpu_release", cpu_resetn, 1'b1);

        // 1) two full words, plus one-cycle latency from the 4th byte to mem_valid
        start_session();
        check("t1_cpu_held", cpu_resetn, 1'b0);
        send(8'h13); send(8'h00); send(8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        tick();
        check("t1_latency", mem_valid, 1'b1);
        rx_valid = 1'b0;
        tick();
        tick();
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        end_session("t1");
        check("t1_nwrites", q_addr.size(), 2);
        check_write("t1_w0", 0, 32'd0, 32'h0000_0013, 32'hF);
        check_write("t1_w1", 1, 32'd1, 32'h0010_0093, 32'hF);
        check("t1_count", word_count, 13'd2);

        // 2) one full word then a one-byte flush
        start_session();
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
        end_session("t2");
        check("t2_nwrites", q_addr.size(), 2);
        check_write("t2_w0", 0, 32'd0, 32'hDDCC_BBAA, 32'hF);
        check_write("t2_w1", 1, 32'd1, 32'h0000_00EE, 32'h1);

        // 3) stalled write: skid keeps the first byte, the second is dropped
        start_session();
        mem_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        cap_addr = mem_addr;
        cap_data = mem_wdata;
        cap_strb = mem_wstrb;
        stable   = mem_valid;
        for (int i = 0; i < 20; i++) begin
            if (i == 3)  begin rx_valid = 1'b1; rx_data = 8'h55; end
            if (i == 10) begin rx_valid = 1'b1; rx_data = 8'h66; end
            tick();
            rx_valid = 1'b0;
            if (!mem_valid || mem_addr !== cap_addr || mem_wdata !== cap_data ||
                mem_wstrb !== cap_strb) stable = 1'b0;
        end
        check("t3_stable", stable, 1'b1);
        check("t3_cap_data", cap_data, 32'h4433_2211);
        check("t3_overflow", overflow, 1'b1);
        mem_ready = 1'b1;
        tick();
        tick();
        send(8'h77); send(8'h88); send(8'h99);
        end_session("t3");
        check("t3_nwrites", q_addr.size(), 2);
        check_write("t3_w0", 0, 32'd0, 32'h4433_2211, 32'hF);
        check_write("t3_w1", 1, 32'd1, 32'h9988_7755, 32'hF);

        // 4) depth limit on the MEM_DEPTH=2 instance; the default instance takes all 3 words
        start_session();
        for (int i = 1; i <= 12; i++) send(8'(i));
        end_session("t4");
        check("t4_small_writes",   n_small_wr, 2);
        check("t4_small_overflow", s_overflow, 1'b1);
        check("t4_small_count",    s_word_count, 13'd2);
        check("t4_main_count",     word_count, 13'd3);
        check("t4_main_overflow",  overflow, 1'b0);
        check_write("t4_w2", 2, 32'd2, 32'h0C0B_0A09, 32'hF);

        // 5) async reset after two bytes
        start_session();
        send(8'hC1); send(8'hC2);
        resetn = 1'b0;
        #1;
        check("t5_valid", mem_valid, 1'b0);
        check("t5_wdata", mem_wdata, 32'd0);
        check("t5_wstrb", mem_wstrb, 4'd0);
        check("t5_cpu",   cpu_resetn, 1'b0);
        check("t5_count", word_count, 13'd0);
        tick();
        resetn = 1'b1;
        tick(); tick(); tick();
        check("t5_idle_cpu", cpu_resetn, 1'b1);
        check("t5_no_write", q_addr.size(), 0);
        programmer_mode = 1'b0;
        tick();
        start_session();
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        end_session("t5");
        check("t5_nwrites", q_addr.size(), 1);
        check_write("t5_w0", 0, 32'd0, 32'hA4A3_A2A1, 32'hF);

        // 6) mode drops during a stalled write with no residual bytes
        start_session();
        mem_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        programmer_mode = 1'b0;
        tick(); tick(); tick();
        check("t6_still_valid", mem_valid, 1'b1);
        check("t6_no_done_yet", done, 1'b0);
        mem_ready = 1'b1;
        tick();
        check("t6_done_after_hs", done, 1'b1);
        tick();
        check("t6_done_one_cycle", done, 1'b0);
        tick();
        check("t6_nwrites", q_addr.size(), 1);
        check("t6_done_pulses", n_done, 1);
        check_write("t6_w0", 0, 32'd0, 32'h0403_0201, 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
